// File: rtl/kbd_scan_queue_if.sv
// Interface bundling the receiver-side, CPU-side and status signals of the scancode queue.
// The master (keyboard receiver / portctl side) drives the strobes and the scancode.
// The slave (the queue) returns the head byte, the status byte and the IRQ1 strobe.
interface kbd_scan_queue_if;
    logic [7:0] ps2_data;
    logic       ps2_hit;
    logic       pop;
    logic       flush;
    logic [7:0] head;
    logic [7:0] status;
    logic       irq;

    modport master (
        output ps2_data, ps2_hit, pop, flush,
        input  head, status, irq
    );

    modport slave (
        input  ps2_data, ps2_hit, pop, flush,
        output head, status, irq
    );
endinterface

// File: rtl/kbd_scan_queue.sv
// PS/2 scancode queue between the keyboard receiver and portctl.
// Bytes are pushed on the rising edge of ps2_hit and held until the CPU pops them.
// head (port 60h), status (port 64h) and irq (IRQ1) are all registered outputs.
// They reflect the queue state one clock after each update.
module kbd_scan_queue #(
    parameter int ADDR_W = 4
) (
    input  logic            clock,
    input  logic            reset,
    kbd_scan_queue_if.slave bus
);
    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_POP = 1'b1;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nx;
    logic              overflow;
    logic              hit_d;
    logic [0:0]        state;
    logic [0:0]        state_nx;
    logic              irq_pend;
    logic              irq_pend_nx;
    logic              irq_q;
    logic [7:0]        head_q;
    logic [7:0]        status_q;

    logic push_req;
    logic full;
    logic nempty;
    logic do_push;
    logic do_pop;
    logic drop;

    // Edge detect, occupancy flags and the push/pop/drop decisions for this cycle.
    always_comb begin
        push_req = bus.ps2_hit & ~hit_d;
        full     = (count == CNT_MAX);
        nempty   = (count != '0);
        do_pop   = bus.pop & nempty;
        // A full queue still accepts a byte when the head leaves in the same cycle.
        do_push  = push_req & (~full | bus.pop);
        drop     = push_req & full & ~bus.pop;
        count_nx = count;
        if (do_push && !do_pop) begin
            count_nx = count + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_nx = count - CNT_ONE;
        end
    end

    // IRQ1 sequencing: strobe on the first byte, then once per pop that leaves data behind.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_nx    = state;
        irq_pend_nx = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count == '0 && count_nx != '0) begin
                    irq_pend_nx = 1'b1;
                    state_nx    = ST_WAIT_POP;
                end
            end
            ST_WAIT_POP: begin
                if (do_pop) begin
                    if (count_nx != '0) begin
                        irq_pend_nx = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Storage array write port; contents are meaningless outside [rd_ptr, wr_ptr).
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset; the pointers and count alone define which entries are valid.
        if (do_push && !bus.flush) begin
            mem[wr_ptr] <= bus.ps2_data;
        end
    end

    // Pointers, count, overflow, FSM and the registered output stage.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            hit_d    <= 1'b0;
            state    <= ST_IDLE;
            irq_pend <= 1'b0;
            irq_q    <= 1'b0;
            head_q   <= 8'h00;
            status_q <= 8'h00;
        end else begin
            hit_d <= bus.ps2_hit;
            if (bus.flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
                state    <= ST_IDLE;
                irq_pend <= 1'b0;
                irq_q    <= 1'b0;
                head_q   <= 8'h00;
                status_q <= 8'h00;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
                count    <= count_nx;
                state    <= state_nx;
                irq_pend <= irq_pend_nx;
                irq_q    <= irq_pend;
                head_q   <= nempty ? mem[rd_ptr] : 8'h00;
                status_q <= {overflow, full, nempty, 5'(count)};
            end
        end
    end

    assign bus.head   = head_q;
    assign bus.status = status_q;
    assign bus.irq    = irq_q;
endmodule

// File: tb/tb_kbd_scan_queue.sv
// Directed bench for kbd_scan_queue: reset, edge detect, overflow, full push+pop,
// IRQ1 sequencing, flush priority and pointer wrap-around.
module tb_kbd_scan_queue;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    kbd_scan_queue_if bus ();

    kbd_scan_queue #(.ADDR_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ps2_data = 8'h00;
        bus.ps2_hit  = 1'b0;
        bus.pop      = 1'b0;
        bus.flush    = 1'b0;
    endtask

    // One ps2_hit pulse; returns once head/status/irq reflect the push.
    task automatic push_byte(input logic [7:0] d);
        bus.ps2_data = d;
        bus.ps2_hit  = 1'b1;
        tick();
        bus.ps2_hit  = 1'b0;
        tick();
    endtask

    task automatic pop_byte();
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        tick();
    endtask

    task automatic push_pop(input logic [7:0] d);
        bus.ps2_data = d;
        bus.ps2_hit  = 1'b1;
        bus.pop      = 1'b1;
        tick();
        bus.ps2_hit  = 1'b0;
        bus.pop      = 1'b0;
        tick();
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_vec++; if (bus.head !== 8'h00) begin n_bad++; $display("FAIL reset_head got=%h exp=00", bus.head); end
        n_vec++; if (bus.status !== 8'h00) begin n_bad++; $display("FAIL reset_status got=%h exp=00", bus.status); end
        n_vec++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
    endtask

    task automatic test_single_push();
        push_byte(8'h1C);
        n_vec++; if (bus.head !== 8'h1C) begin n_bad++; $display("FAIL push1_head got=%h exp=1c", bus.head); end
        n_vec++; if (bus.status !== 8'h21) begin n_bad++; $display("FAIL push1_status got=%h exp=21", bus.status); end
        n_vec++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL push1_irq got=%b exp=1", bus.irq); end
        tick();
        n_vec++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL push1_irq_width got=%b exp=0", bus.irq); end
    endtask

    task automatic test_held_hit();
        int irqs;
        irqs = 0;
        do_flush();
        bus.ps2_data = 8'h2A;
        bus.ps2_hit  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.irq === 1'b1) irqs++;
        end
        bus.ps2_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.irq === 1'b1) irqs++;
        end
        n_vec++; if (irqs != 1) begin n_bad++; $display("FAIL held_irq_count got=%0d exp=1", irqs); end
        n_vec++; if (bus.status !== 8'h21) begin n_bad++; $display("FAIL held_status got=%h exp=21", bus.status); end
        n_vec++; if (bus.head !== 8'h2A) begin n_bad++; $display("FAIL held_head got=%h exp=2a", bus.head); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b;
        logic       exp_irq;
        do_flush();
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        n_vec++; if (bus.status !== 8'hF0) begin n_bad++; $display("FAIL ovf_status got=%h exp=f0", bus.status); end
        n_vec++; if (bus.head !== 8'h00) begin n_bad++; $display("FAIL ovf_head got=%h exp=00", bus.head); end
        for (int i = 0; i < 16; i++) begin
            exp_b   = 8'(i);
            exp_irq = (i < 15);
            n_vec++; if (bus.head !== exp_b) begin n_bad++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, bus.head, exp_b); end
            pop_byte();
            n_vec++; if (bus.irq !== exp_irq) begin n_bad++; $display("FAIL ovf_pop_irq[%0d] got=%b exp=%b", i, bus.irq, exp_irq); end
        end
        n_vec++; if (bus.head !== 8'h00) begin n_bad++; $display("FAIL ovf_drained_head got=%h exp=00", bus.head); end
        n_vec++; if (bus.status !== 8'h80) begin n_bad++; $display("FAIL ovf_sticky_status got=%h exp=80", bus.status); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_b;
        do_flush();
        for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i));
        n_vec++; if (bus.status !== 8'h70) begin n_bad++; $display("FAIL full_status got=%h exp=70", bus.status); end
        push_pop(8'h55);
        n_vec++; if (bus.status !== 8'h70) begin n_bad++; $display("FAIL full_pp_status got=%h exp=70", bus.status); end
        n_vec++; if (bus.head !== 8'h31) begin n_bad++; $display("FAIL full_pp_head got=%h exp=31", bus.head); end
        n_vec++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL full_pp_irq got=%b exp=1", bus.irq); end
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'h31 + 8'(i) : 8'h55;
            n_vec++; if (bus.head !== exp_b) begin n_bad++; $display("FAIL full_order[%0d] got=%h exp=%h", i, bus.head, exp_b); end
            pop_byte();
        end
        n_vec++; if (bus.status !== 8'h00) begin n_bad++; $display("FAIL full_drained_status got=%h exp=00", bus.status); end
    endtask

    task automatic test_irq_sequence();
        do_flush();
        push_byte(8'hF0);
        n_vec++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL seq_push1_irq got=%b exp=1", bus.irq); end
        push_byte(8'hE0);
        n_vec++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL seq_push2_irq got=%b exp=0", bus.irq); end
        n_vec++; if (bus.status !== 8'h22) begin n_bad++; $display("FAIL seq_status2 got=%h exp=22", bus.status); end
        pop_byte();
        n_vec++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL seq_pop1_irq got=%b exp=1", bus.irq); end
        n_vec++; if (bus.head !== 8'hE0) begin n_bad++; $display("FAIL seq_pop1_head got=%h exp=e0", bus.head); end
        pop_byte();
        n_vec++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL seq_pop2_irq got=%b exp=0", bus.irq); end
        n_vec++; if (bus.head !== 8'h00) begin n_bad++; $display("FAIL seq_pop2_head got=%h exp=00", bus.head); end
        pop_byte();
        n_vec++; if (bus.status !== 8'h00) begin n_bad++; $display("FAIL seq_pop_empty_status got=%h exp=00", bus.status); end
        n_vec++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL seq_pop_empty_irq got=%b exp=0", bus.irq); end
    endtask

    task automatic test_flush_priority();
        do_flush();
        for (int i = 0; i < 17; i++) push_byte(8'h60 + 8'(i));
        for (int i = 0; i < 13; i++) pop_byte();
        n_vec++; if (bus.status !== 8'hA3) begin n_bad++; $display("FAIL flush_pre_status got=%h exp=a3", bus.status); end
        n_vec++; if (bus.head !== 8'h6D) begin n_bad++; $display("FAIL flush_pre_head got=%h exp=6d", bus.head); end
        bus.ps2_data = 8'h99;
        bus.ps2_hit  = 1'b1;
        bus.pop      = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.ps2_hit  = 1'b0;
        bus.pop      = 1'b0;
        bus.flush    = 1'b0;
        tick();
        n_vec++; if (bus.status !== 8'h00) begin n_bad++; $display("FAIL flush_status got=%h exp=00", bus.status); end
        n_vec++; if (bus.head !== 8'h00) begin n_bad++; $display("FAIL flush_head got=%h exp=00", bus.head); end
        n_vec++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL flush_irq got=%b exp=0", bus.irq); end
        tick();
        tick();
        n_vec++; if (bus.status !== 8'h00) begin n_bad++; $display("FAIL flush_edge_lost_status got=%h exp=00", bus.status); end
        n_vec++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL flush_edge_lost_irq got=%b exp=0", bus.irq); end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        do_flush();
        push_byte(8'hA0);
        for (int i = 0; i < 40; i++) begin
            d = 8'hB0 + 8'(i);
            push_pop(d);
            n_vec++; if (bus.head !== d) begin n_bad++; $display("FAIL wrap_head[%0d] got=%h exp=%h", i, bus.head, d); end
            n_vec++; if (bus.status !== 8'h21) begin n_bad++; $display("FAIL wrap_status[%0d] got=%h exp=21", i, bus.status); end
            n_vec++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL wrap_irq[%0d] got=%b exp=1", i, bus.irq); end
        end
        pop_byte();
        n_vec++; if (bus.status !== 8'h00) begin n_bad++; $display("FAIL wrap_final_status got=%h exp=00", bus.status); end
        n_vec++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL wrap_final_irq got=%b exp=0", bus.irq); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_held_hit();
        test_overflow();
        test_full_push_pop();
        test_irq_sequence();
        test_flush_priority();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
